// File: rtl/tensor_core_pkg.sv
// Shared definitions for the vocabulary matcher front end.
package tensor_core_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    TERM   = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_e;

  localparam logic [7:0] NULL_CHAR     = 8'h00;
  localparam logic [7:0] DELIM_DEFAULT = 8'h20;

endpackage

// File: rtl/word_loader.sv
// Splits a character stream into words and loads each one, null-terminated,
// into the matcher input RAM, then starts the matcher and waits for it.
module word_loader
  import tensor_core_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM      = DATA_WIDTH'(DELIM_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cs,
  input  logic                  match_done,
  output logic [7:0]            word_count,
  output logic                  overflow,
  output logic                  text_done
);

  // Last address is kept free for the terminator.
  localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = '1;
  localparam logic [DATA_WIDTH-1:0] NUL       = DATA_WIDTH'(NULL_CHAR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic                  eot_q, eot_d;
  logic                  s_ready_d, ram_we_d, cs_d, overflow_d, text_done_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_d;
  logic [7:0]            word_count_d;
  logic                  accept;

  assign accept = s_valid && s_ready;

  // State, pointer and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wptr_q     <= '0;
      eot_q      <= 1'b0;
      s_ready    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cs         <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
      text_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      eot_q      <= eot_d;
      s_ready    <= s_ready_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      cs         <= cs_d;
      word_count <= word_count_d;
      overflow   <= overflow_d;
      text_done  <= text_done_d;
    end
  end

  // Next state and next output values; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    eot_d        = eot_q;
    s_ready_d    = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    cs_d         = 1'b0;
    word_count_d = word_count;
    overflow_d   = overflow;
    text_done_d  = 1'b0;
    case (state_q)
      FILL: begin
        s_ready_d = 1'b1;
        if (accept) begin
          if (s_data == NUL) begin
            if (wptr_q != '0) begin
              eot_d     = 1'b1;
              state_d   = TERM;
              s_ready_d = 1'b0;
            end else begin
              text_done_d = 1'b1;
            end
          end else if (s_data == DELIM) begin
            // Leading or repeated delimiters never create empty words.
            if (wptr_q != '0) begin
              state_d   = TERM;
              s_ready_d = 1'b0;
            end
          end else if (wptr_q != WPTR_LAST) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = wptr_q;
            ram_wdata_d = s_data;
            wptr_d      = wptr_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      TERM: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = wptr_q;
        ram_wdata_d = NUL;
        state_d     = LAUNCH;
      end
      LAUNCH: begin
        cs_d    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (match_done) begin
          word_count_d = word_count + 8'd1;
          wptr_d       = '0;
          s_ready_d    = 1'b1;
          state_d      = FILL;
          if (eot_q) begin
            text_done_d = 1'b1;
            eot_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = FILL;
        wptr_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_word_loader.sv
// Scoreboard bench for word_loader: a text-level model predicts RAM writes,
// matcher launches and end-of-text pulses; a monitor checks them as they occur.
module tb_word_loader;

  localparam logic [7:0] SP = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cs;
  logic       match_done;
  logic [7:0] word_count;
  logic       overflow;
  logic       text_done;

  word_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cs         (cs),
    .match_done (match_done),
    .word_count (word_count),
    .overflow   (overflow),
    .text_done  (text_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_wr[$];     // {addr, data}
  int          exp_cs_wr[$];  // writes expected to be complete at launch
  logic [7:0]  exp_cs_wc[$];  // word_count expected at launch
  logic [7:0]  exp_td[$];     // word_count expected at end-of-text pulse
  logic [7:0]  txt[$];
  int          wr_total = 0;
  int          wr_seen  = 0;
  logic [7:0]  wc_exp   = 8'd0;
  logic        ov_exp   = 1'b0;
  int          md_delay = 3;
  logic        md_en    = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // Reference model: split the text into words and predict every effect.
  task automatic emit_word(input int len);
    int n;
    n = (len > 15) ? 15 : len;
    exp_wr.push_back({4'(n), 8'h00});
    wr_total++;
    exp_cs_wr.push_back(wr_total);
    exp_cs_wc.push_back(wc_exp);
    wc_exp = wc_exp + 8'd1;
  endtask

  task automatic model_text();
    int len;
    len = 0;
    foreach (txt[i]) begin
      if (txt[i] == 8'h00) begin
        if (len > 0) emit_word(len);
        exp_td.push_back(wc_exp);
        len = 0;
      end else if (txt[i] == SP) begin
        if (len > 0) emit_word(len);
        len = 0;
      end else begin
        if (len < 15) begin
          exp_wr.push_back({4'(len), txt[i]});
          wr_total++;
        end else begin
          ov_exp = 1'b1;
        end
        len++;
      end
    end
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) txt.push_back(s[i]);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = c;
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("send_timeout", 32'(n), 0);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
  endtask

  task automatic run_text(input int gapmax);
    model_text();
    foreach (txt[i]) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send(txt[i]);
    end
    txt.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr.size() + exp_cs_wr.size() + exp_td.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (md_delay + 4) @(negedge clk);
    chk("drain_pending", 32'(exp_wr.size() + exp_cs_wr.size() + exp_td.size()), 0);
  endtask

  // Monitor: compare every DUT event against the scoreboard queues.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ram_we) begin
          if (exp_wr.size() == 0) unexpected("ram_write");
          else begin
            e = exp_wr.pop_front();
            chk("ram_addr", 32'(ram_addr), 32'(e[11:8]));
            chk("ram_wdata", 32'(ram_wdata), 32'(e[7:0]));
          end
          wr_seen++;
        end
        if (cs) begin
          if (exp_cs_wr.size() == 0) unexpected("cs");
          else begin
            chk("cs_after_terminator", 32'(wr_seen), 32'(exp_cs_wr.pop_front()));
            chk("cs_word_count", 32'(word_count), 32'(exp_cs_wc.pop_front()));
          end
        end
        if (text_done) begin
          if (exp_td.size() == 0) unexpected("text_done");
          else chk("text_done_word_count", 32'(word_count), 32'(exp_td.pop_front()));
        end
      end
    end
  end

  // Matcher stand-in: answers each launch after md_delay cycles, checking the stall.
  initial begin
    int d;
    match_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cs && md_en && rst_n) begin
        d = md_delay;
        repeat (d) begin
          @(negedge clk);
          chk("stall_s_ready", 32'(s_ready), 0);
          chk("stall_no_write", 32'(ram_we), 0);
          chk("stall_no_cs", 32'(cs), 0);
        end
        match_done = 1'b1;
        @(negedge clk);
        match_done = 1'b0;
        chk("ready_after_done", 32'(s_ready), 1);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, "_cs"}, 32'(cs), 0);
    chk({tag, "_word_count"}, 32'(word_count), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_text_done"}, 32'(text_done), 0);
  endtask

  initial begin
    int nw;
    int len;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(s_ready), 1);

    // "cat\0" with a 3-cycle matcher
    md_delay = 3;
    add_str("cat"); txt.push_back(8'h00);
    run_text(0);
    drain();
    chk("wc_after_cat", 32'(word_count), 1);

    // "ab  cd\0" with immediate matcher response
    md_delay = 0;
    add_str("ab  cd"); txt.push_back(8'h00);
    run_text(1);
    drain();
    chk("wc_after_abcd", 32'(word_count), 3);

    // 20 characters into a 16-entry RAM, then one more word
    md_delay = 2;
    repeat (20) txt.push_back("x");
    txt.push_back(8'h00);
    run_text(0);
    drain();
    chk("overflow_set", 32'(overflow), 1);
    add_str("hi"); txt.push_back(8'h00);
    run_text(0);
    drain();
    chk("overflow_sticky", 32'(overflow), 1);

    // Long matcher stall with the next character already offered
    md_delay = 50;
    add_str("go"); txt.push_back(8'h00);
    add_str("z"); txt.push_back(8'h00);
    run_text(0);
    md_delay = 2;
    drain();
    chk("wc_after_stall", 32'(word_count), 32'(wc_exp));

    // Asynchronous reset while waiting on the matcher
    md_en = 1'b0;
    add_str("hello ");
    run_text(0);
    len = 0;
    while (exp_cs_wr.size() != 0 && len < 100) begin
      @(negedge clk);
      len++;
    end
    chk("reset_test_cs_seen", 32'(exp_cs_wr.size()), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("reset_held");
    rst_n  = 1'b1;
    wc_exp = 8'd0;
    ov_exp = 1'b0;
    md_en  = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 32'(s_ready), 1);
    chk("wc_after_midreset", 32'(word_count), 0);

    // End of text with no pending word
    txt.push_back(8'h00);
    run_text(0);
    drain();
    chk("wc_after_empty_text", 32'(word_count), 0);

    // Randomized texts
    for (int t = 0; t < 30; t++) begin
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 2)) txt.push_back(SP);
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 6);
        repeat (len) txt.push_back(8'("a" + $urandom_range(0, 25)));
      end
      if ($urandom_range(0, 1) == 1) txt.push_back(SP);
      txt.push_back(8'h00);
      md_delay = $urandom_range(0, 4);
      run_text(2);
    end
    drain();

    chk("final_word_count", 32'(word_count), 32'(wc_exp));
    chk("final_overflow", 32'(overflow), 32'(ov_exp));
    chk("final_writes", 32'(wr_seen), 32'(wr_total));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
